// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: shared types and constants for the UART transmit path.
// Revision 1.0
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// sync_fifo: single-clock show-ahead FIFO; dout always presents the head entry.
// Revision 1.0
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (ADDR_W + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_byte_fifo.sv
`default_nettype none
// uart_tx_byte_fifo: buffers a no-backpressure byte stream and sends it as 8N1 UART.
// Revision 1.0
module uart_tx_byte_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_dv,
  input  logic [7:0] byte_in,
  output logic       tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(UART_DATA_BITS);

  tx_state_e                 state, state_n;
  logic [BAUD_W-1:0]         baud, baud_n;
  logic [BIT_W-1:0]          bit_idx, bit_n;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_n;
  logic                      tx_n;
  logic                      pop;
  logic                      push;
  logic                      empty;
  logic                      baud_last;
  logic [7:0]                head;
  logic [ADDR_W:0]           count;

  // A full FIFO still accepts a byte when the transmitter frees a slot this cycle.
  assign push = byte_dv & (~fifo_full | pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (byte_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (empty),
    .count (count)
  );

  assign baud_last = (baud == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n = state;
    baud_n  = baud + 1'b1;
    bit_n   = bit_idx;
    shift_n = shift_reg;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_n  = '0;
          shift_n = shift_reg >> 1;
          bit_n   = bit_idx + 1'b1;
          if (bit_idx == BIT_W'(UART_DATA_BITS - 1)) state_n = STOP;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_n = '0;
          // Chain straight into the next frame so bursts leave no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        baud_n  = '0;
        state_n = IDLE;
      end
    endcase

    tx_n = 1'b1;
    if (state_n == START)     tx_n = 1'b0;
    else if (state_n == DATA) tx_n = shift_n[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      baud      <= baud_n;
      bit_idx   <= bit_n;
      shift_reg <= shift_n;
      tx        <= tx_n;
      tx_busy   <= (state != IDLE) | (count != '0);
      overflow  <= byte_dv & fifo_full & ~pop;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_byte_fifo.sv
`default_nettype none
// tb_uart_tx_byte_fifo: directed and random stimulus against a frame-timing reference model.
// Revision 1.0
module tb_uart_tx_byte_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       byte_dv = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       tx, tx_busy, fifo_full, overflow;

  int errors = 0;
  int checks = 0;
  int ovf_seen = 0;

  // Reference model: queue of buffered bytes plus time left in the frame on the line.
  logic [7:0] q[$];
  int         rem = 0;
  logic [7:0] cur = 8'h00;
  logic       exp_ovf = 1'b0;

  uart_tx_byte_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_dv   (byte_dv),
    .byte_in   (byte_in),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_tx();
    int k;
    if (rem == 0) return 1'b1;
    k = (FRAME - rem) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic model_busy();
    return (rem > 0) || (q.size() > 0);
  endfunction

  task automatic model_reset();
    q.delete();
    rem     = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic model_edge(input logic dv, input logic [7:0] d);
    logic do_pop, acc;
    do_pop = (rem <= 1) && (q.size() > 0);
    acc    = dv && ((q.size() < DEPTH) || do_pop);
    if (do_pop) begin
      cur = q.pop_front();
      rem = FRAME;
    end else if (rem > 0) begin
      rem--;
    end
    if (acc) q.push_back(d);
    exp_ovf = dv && !acc;
  endtask

  // One clock: drive inputs, advance the model at the edge, then compare just after it.
  task automatic cycle(input logic dv, input logic [7:0] d);
    logic busy_before, busy_after;
    byte_dv = dv;
    byte_in = d;
    busy_before = model_busy();
    @(posedge clk);
    if (rst) model_edge(dv, d);
    #1;
    busy_after = model_busy();
    chk("tx", {31'b0, tx}, {31'b0, model_tx()});
    chk("fifo_full", {31'b0, fifo_full}, {31'b0, (q.size() == DEPTH)});
    chk("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
    if (busy_before == busy_after) chk("tx_busy", {31'b0, tx_busy}, {31'b0, busy_after});
    if (overflow === 1'b1) ovf_seen++;
    byte_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic drain();
    int budget;
    budget = 2000;
    while ((rem > 0 || q.size() > 0) && budget > 0) begin
      cycle(1'b0, 8'h00);
      budget--;
    end
    chk("drain_timeout", {31'b0, (budget == 0)}, 32'd0);
    idle(2);
  endtask

  // Pulse reset mid-cycle; tx must return high before the next edge.
  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    chk("tx_in_reset", {31'b0, tx}, 32'd1);
    chk("busy_in_reset", {31'b0, tx_busy}, 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int base, budget;

    // Reset state and long idle period.
    idle(3);
    @(negedge clk);
    rst = 1'b1;
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, tx_busy}, 32'd0);
    chk("rst_full", {31'b0, fifo_full}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    idle(100);

    // Reset during a start bit forces the line high immediately.
    cycle(1'b1, 8'h00);
    idle(3);
    chk("start_low", {31'b0, tx}, 32'd0);
    pulse_reset();
    idle(20);

    // Single byte 0xA5, line sequence checked cycle by cycle.
    cycle(1'b1, 8'hA5);
    chk("a5_not_yet", {31'b0, tx}, 32'd1);
    cycle(1'b0, 8'h00);
    chk("a5_start", {31'b0, tx}, 32'd0);
    idle(FRAME - 1);
    chk("a5_stop_busy", {31'b0, tx_busy}, 32'd1);
    drain();
    chk("a5_idle_busy", {31'b0, tx_busy}, 32'd0);

    // Splitter burst: two frames back to back with no overflow.
    base = ovf_seen;
    cycle(1'b1, 8'h34);
    cycle(1'b1, 8'h12);
    drain();
    chk("burst_ovf", ovf_seen - base, 32'd0);

    // Six bytes into a four-deep FIFO: exactly one drop.
    base = ovf_seen;
    for (int i = 1; i <= 6; i++) cycle(1'b1, 8'(i));
    chk("six_full", {31'b0, fifo_full}, 32'd1);
    drain();
    chk("six_ovf_pulses", ovf_seen - base, 32'd1);

    // Full FIFO with a byte arriving on the STOP-to-START pop cycle.
    base = ovf_seen;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hC0 + 8'(i));
    chk("coinc_full", {31'b0, fifo_full}, 32'd1);
    budget = 200;
    while (rem != 1 && budget > 0) begin
      cycle(1'b0, 8'h00);
      budget--;
    end
    chk("coinc_timeout", {31'b0, (budget == 0)}, 32'd0);
    cycle(1'b1, 8'h5A);
    chk("coinc_still_full", {31'b0, fifo_full}, 32'd1);
    chk("coinc_no_ovf", {31'b0, overflow}, 32'd0);
    drain();
    chk("coinc_ovf_pulses", ovf_seen - base, 32'd0);

    // Reset during data bit 3 of 0xFF, then release with FIFO empty.
    cycle(1'b1, 8'hFF);
    idle(CPB + 3 * CPB + 2);
    pulse_reset();
    idle(60);
    chk("post_rst_tx", {31'b0, tx}, 32'd1);
    chk("post_rst_busy", {31'b0, tx_busy}, 32'd0);

    // Random traffic with bursts dense enough to overflow.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) cycle(1'b1, 8'($urandom));
      else                          cycle(1'b0, 8'h00);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_byte_fifo.md
Name: uart_tx_byte_fifo

Overview:
- Downstream consumer of the word-to-byte splitter: accepts its back-to-back byte_dv/byte stream with no backpressure.
- Buffers bytes in a small synchronous FIFO and serialises them on a UART TX line, 8N1, LSB first.
- Absorbs the splitter's 2-byte bursts, which arrive faster than the line rate.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
FIFO_DEPTH, 8, byte entries; power of two, >= 2.
ADDR_W, $clog2(FIFO_DEPTH), pointer width; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
byte_dv  in  1  byte valid strobe; one byte per high cycle.
byte_in  in  8  data byte, sampled when byte_dv = 1.
tx  out  1  UART serial output, idle high.
tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty.
fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
overflow  out  1  one-cycle pulse: a byte was dropped.

Behaviour:
- Reset (rst = 0, asynchronous):
  - tx = 1, tx_busy = 0, fifo_full = 0, overflow = 0.
  - Pointers and count = 0, state = IDLE, baud counter = 0, bit index = 0.
  - Reset mid-frame aborts the frame immediately; tx returns high.
- FIFO count is ADDR_W+1 bits wide; pointers wrap modulo FIFO_DEPTH.
- Push when byte_dv = 1 and (count < FIFO_DEPTH, or a pop occurs in the same cycle).
- Full with no same-cycle pop: byte discarded, overflow = 1 on the next cycle, FIFO unchanged.
- Simultaneous push and pop: count unchanged, both pointers advance.
- State machine:
  - IDLE: if count != 0, pop the head into shift_reg, clear the baud counter, go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift_reg[0] for CLKS_PER_BIT cycles, then shift right and increment bit index. After bit 7, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles. At the final cycle, if count != 0, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and clears on every state transition.
- tx is driven from a register (glitch-free).
- Latency: byte_dv sampled at edge N → FIFO not empty after N → pop at edge N+1 → tx falls after edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles; back-to-back frames have zero gap.
- tx_busy = (state != IDLE) | (count != 0), registered.
- fifo_full is combinational from count.

Decomposition:
- Package uart_pkg:
  - tx state enum (IDLE, START, DATA, STOP), 2 bits.
  - UART_DATA_BITS = 8.
  - Default CLKS_PER_BIT constant.
- Sub-module sync_fifo: parameters WIDTH and DEPTH; ports push, pop, din, dout (head, show-ahead), full, empty, count.
- Overflow detection and the TX FSM stay in the top module.

Test Plan (CLKS_PER_BIT = 4, FIFO_DEPTH = 4):
1. Reset release, no input → tx = 1, tx_busy = 0 for 100 cycles; asserting rst = 0 mid-run forces tx = 1 within the same cycle.
2. Single byte 0xA5 → tx low 2 edges after byte_dv. Line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_busy drops after the 40-cycle frame.
3. Splitter burst 0x34 then 0x12 on consecutive cycles → two frames back-to-back (80 cycles, no idle gap), 0x34 first; overflow never asserted.
4. Six bytes 0x01..0x06 on consecutive cycles → 0x01 popped at once and FIFO refills. fifo_full reaches 1; the single byte beyond capacity is dropped with one overflow pulse. Line carries 0x01..0x05 only.
5. FIFO full and byte_dv coincident with the STOP→START pop → byte accepted, no overflow, count unchanged.
6. rst asserted during DATA bit 3 of 0xFF, then released with FIFO empty → tx = 1, tx_busy = 0, no residual frame emitted.
